// File: rtl/rtc_pkg.sv
// Shared constants and FSM state type for the RTC snapshot reader.
// Holds the default register map, field/address widths and the
// state encoding used by mem_to_bcd.
package rtc_pkg;

    localparam int BCD_W  = 8;
    localparam int ADDR_W = 4;
    localparam int SLOT_W = 3;

    localparam int unsigned SEC_ADDR_DEF    = 0;
    localparam int unsigned MIN_ADDR_DEF    = 1;
    localparam int unsigned HOUR_ADDR_DEF   = 2;
    localparam int unsigned DAYS_ADDR_DEF   = 3;
    localparam int unsigned MONTHS_ADDR_DEF = 4;
    localparam int unsigned YEARS_ADDR_DEF  = 5;

    // Six register reads per snapshot, slots 0..5
    localparam logic [SLOT_W-1:0] LAST_SLOT = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_field_check.sv
// Combinational validity check for one packed-BCD byte: both nibbles
// must be decimal digits and the value must lie within MIN_VAL..MAX_VAL.
// Bounds that can never be violated generate no comparator.
module bcd_field_check
    import rtc_pkg::*;
#(
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned MAX_VAL = 'h99
)(
    input  logic [BCD_W-1:0] value,
    output logic             err
);

    localparam logic [BCD_W-1:0] MIN_B = BCD_W'(MIN_VAL);
    localparam logic [BCD_W-1:0] MAX_B = BCD_W'(MAX_VAL);

    logic nibble_err;
    logic below_min;
    logic above_max;

    assign nibble_err = (value[7:4] > 4'd9) || (value[3:0] > 4'd9);

    if (MIN_VAL > 0) begin : g_min
        assign below_min = (value < MIN_B);
    end else begin : g_no_min
        assign below_min = 1'b0;
    end

    if (MAX_VAL < 'hFF) begin : g_max
        assign above_max = (value > MAX_B);
    end else begin : g_no_max
        assign above_max = 1'b0;
    end

    assign err = nibble_err || below_min || above_max;

endmodule

// File: rtl/mem_to_bcd.sv
// Reads six RTC registers (sec, min, hour, days, months, years) from a
// one-cycle-latency memory on request and presents them as an atomic
// snapshot held until the consumer accepts it.
// Optional feature: define RTC_RD_BCD_CHECK_EN to build per-field BCD
// range checking that drives bcd_err alongside the snapshot.
module mem_to_bcd
    import rtc_pkg::*;
#(
    parameter int unsigned SEC_ADDR    = SEC_ADDR_DEF,
    parameter int unsigned MIN_ADDR    = MIN_ADDR_DEF,
    parameter int unsigned HOUR_ADDR   = HOUR_ADDR_DEF,
    parameter int unsigned DAYS_ADDR   = DAYS_ADDR_DEF,
    parameter int unsigned MONTHS_ADDR = MONTHS_ADDR_DEF,
    parameter int unsigned YEARS_ADDR  = YEARS_ADDR_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [BCD_W-1:0]  rd_data,
    output logic [BCD_W-1:0]  sec_bcd,
    output logic [BCD_W-1:0]  min_bcd,
    output logic [BCD_W-1:0]  hour_bcd,
    output logic [BCD_W-1:0]  days_bcd,
    output logic [BCD_W-1:0]  months_bcd,
    output logic [BCD_W-1:0]  years_bcd,
    output logic              snap_valid,
    input  logic              snap_ready,
    output logic              busy,
    output logic              bcd_err
);

    state_t              state, state_next;
    logic [SLOT_W-1:0]   slot, slot_next;
    logic                rd_en_next;
    logic [ADDR_W-1:0]   rd_addr_next;
    logic                load_snap;

    // Read pipeline: tags the data returning one cycle after each strobe
    logic                cap_valid;
    logic [SLOT_W-1:0]   cap_slot;

    logic [BCD_W-1:0]    sec_sh, min_sh, hour_sh, days_sh, months_sh, years_sh;

    // Map a read slot to its configured register address
    function automatic logic [ADDR_W-1:0] slot_addr(input logic [SLOT_W-1:0] s);
        case (s)
            3'd0:    return ADDR_W'(SEC_ADDR);
            3'd1:    return ADDR_W'(MIN_ADDR);
            3'd2:    return ADDR_W'(HOUR_ADDR);
            3'd3:    return ADDR_W'(DAYS_ADDR);
            3'd4:    return ADDR_W'(MONTHS_ADDR);
            default: return ADDR_W'(YEARS_ADDR);
        endcase
    endfunction

    // Next-state, next read strobe/address and snapshot-load decision
    always_comb begin
        state_next   = state;
        slot_next    = slot;
        rd_en_next   = 1'b0;
        rd_addr_next = rd_addr;
        load_snap    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = READ;
                    slot_next    = '0;
                    rd_en_next   = 1'b1;
                    rd_addr_next = slot_addr('0);
                end
            end
            READ: begin
                if (slot == LAST_SLOT) begin
                    state_next = DRAIN;
                end else begin
                    slot_next    = slot + 3'd1;
                    rd_en_next   = 1'b1;
                    rd_addr_next = slot_addr(slot + 3'd1);
                end
            end
            DRAIN: begin
                state_next = HOLD;
                load_snap  = 1'b1;
            end
            HOLD: begin
                if (snap_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, slot counter and registered read interface
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            slot    <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
        end else begin
            state   <= state_next;
            slot    <= slot_next;
            rd_en   <= rd_en_next;
            rd_addr <= rd_addr_next;
        end
    end

    // Capture returning read data into the shadow byte of its slot
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_valid <= 1'b0;
            cap_slot  <= '0;
            sec_sh    <= '0;
            min_sh    <= '0;
            hour_sh   <= '0;
            days_sh   <= '0;
            months_sh <= '0;
            years_sh  <= '0;
        end else begin
            cap_valid <= rd_en;
            cap_slot  <= slot;
            if (cap_valid) begin
                case (cap_slot)
                    3'd0:    sec_sh    <= rd_data;
                    3'd1:    min_sh    <= rd_data;
                    3'd2:    hour_sh   <= rd_data;
                    3'd3:    days_sh   <= rd_data;
                    3'd4:    months_sh <= rd_data;
                    default: years_sh  <= rd_data;
                endcase
            end
        end
    end

    // Publish all six fields at once; the years byte arrives on the load edge itself
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_bcd    <= '0;
            min_bcd    <= '0;
            hour_bcd   <= '0;
            days_bcd   <= '0;
            months_bcd <= '0;
            years_bcd  <= '0;
        end else if (load_snap) begin
            sec_bcd    <= sec_sh;
            min_bcd    <= min_sh;
            hour_bcd   <= hour_sh;
            days_bcd   <= days_sh;
            months_bcd <= months_sh;
            years_bcd  <= rd_data;
        end
    end

    assign busy       = (state == READ) || (state == DRAIN);
    assign snap_valid = (state == HOLD);

`ifdef RTC_RD_BCD_CHECK_EN
    logic [5:0] field_err;
    logic       bcd_err_q;

    bcd_field_check #(.MIN_VAL('h00), .MAX_VAL('h59)) u_chk_sec (
        .value(sec_sh),    .err(field_err[0]));
    bcd_field_check #(.MIN_VAL('h00), .MAX_VAL('h59)) u_chk_min (
        .value(min_sh),    .err(field_err[1]));
    bcd_field_check #(.MIN_VAL('h00), .MAX_VAL('h23)) u_chk_hour (
        .value(hour_sh),   .err(field_err[2]));
    bcd_field_check #(.MIN_VAL('h01), .MAX_VAL('h31)) u_chk_days (
        .value(days_sh),   .err(field_err[3]));
    bcd_field_check #(.MIN_VAL('h01), .MAX_VAL('h12)) u_chk_months (
        .value(months_sh), .err(field_err[4]));
    bcd_field_check #(.MIN_VAL('h00), .MAX_VAL('hFF)) u_chk_years (
        .value(rd_data),   .err(field_err[5]));

    // Error flag travels with the snapshot it describes
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_err_q <= 1'b0;
        end else if (load_snap) begin
            bcd_err_q <= |field_err;
        end
    end

    assign bcd_err = bcd_err_q;
`else
    assign bcd_err = 1'b0;
`endif

endmodule

// File: doc/mem_to_bcd.md
MEM_TO_BCD -- requirements
Module: mem_to_bcd

Interface
REQ-001 SHALL have parameter SEC_ADDR, default 0, memory address of the seconds register.
REQ-002 SHALL have parameters MIN_ADDR, HOUR_ADDR, DAYS_ADDR, MONTHS_ADDR and YEARS_ADDR, defaults 1, 2, 3, 4 and 5, holding the minutes, hours, days, months and years register addresses.
REQ-003 SHALL have a single clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  snapshot request, sampled in IDLE only.
REQ-007 rd_en  output  1  memory read strobe, registered.
REQ-008 rd_addr  output  4  memory read address, registered.
REQ-009 rd_data  input  8  memory read data, valid exactly 1 cycle after rd_en.
REQ-010 sec_bcd, min_bcd, hour_bcd, days_bcd, months_bcd, years_bcd  output  8 each  last completed snapshot.
REQ-011 snap_valid  output  1  snapshot available.
REQ-012 snap_ready  input  1  consumer accepts snapshot.
REQ-013 busy  output  1  read sequence in progress.
REQ-014 bcd_err  output  1  snapshot failed range check; qualified by snap_valid.

Function
REQ-015 SHALL implement the FSM states IDLE, READ, DRAIN and HOLD.
REQ-016 IDLE: start=1 at cycle T moves the FSM to READ; rd_en=1 during T+1..T+6 with rd_addr = SEC, MIN, HOUR, DAYS, MONTHS, YEARS addresses, in that order, one per cycle.
REQ-017 The block SHALL capture rd_data into internal shadow registers at the clock edges closing cycles T+2..T+7; the FSM is in DRAIN during T+7.
REQ-018 The block SHALL copy all six shadow bytes to the field outputs atomically and assert snap_valid from cycle T+8, for a start-to-valid latency of 8 cycles; the FSM enters HOLD.
REQ-019 Field outputs SHALL hold the previous snapshot unchanged during READ and DRAIN.
REQ-020 busy SHALL be 1 exactly in READ and DRAIN.
REQ-021 rd_en SHALL be 0 outside cycles T+1..T+6.
REQ-022 HOLD: snap_valid, the fields and bcd_err SHALL stay stable until snap_valid&&snap_ready; the FSM then returns to IDLE on the next cycle.
REQ-023 start asserted in READ, DRAIN or HOLD SHALL be ignored and not queued, including in the handshake cycle itself.
REQ-024 snap_ready SHALL have no effect while snap_valid=0.
REQ-025 The read-slot counter SHALL be 3 bits and SHALL never wrap past slot 5.

Reset
REQ-026 rst=1 SHALL force IDLE on the next edge from any state, abandoning any sequence in progress.
REQ-027 Reset values: rd_en=0, rd_addr=0, busy=0, snap_valid=0, bcd_err=0, all field outputs and shadows 0x00.
REQ-028 rst SHALL take priority over start and snap_ready in the same cycle.

Configuration
REQ-029 With macro RTC_RD_BCD_CHECK_EN defined, bcd_err SHALL be registered with the snapshot and set if any byte fails its check.
REQ-030 Checks: any nibble > 9; sec or min > 0x59; hour > 0x23; days outside 0x01..0x31; months outside 0x01..0x12. years requires only valid nibbles.
REQ-031 A snapshot with bcd_err=1 SHALL still be delivered unaltered.
REQ-032 Without RTC_RD_BCD_CHECK_EN, bcd_err SHALL be constant 0 and no check logic is built.

Structure
REQ-033 Package rtc_pkg SHALL hold the register address constants 0..5, the BCD byte width of 8, the address width of 4 and the FSM state enum.
REQ-034 Sub-module bcd_field_check SHALL be combinational, with parameters MIN_VAL and MAX_VAL, input byte and output err; it is instantiated six times, only under RTC_RD_BCD_CHECK_EN.

Verification
REQ-035 Memory model preloaded with 0x45, 0x59, 0x23, 0x31, 0x12, 0x99, start pulse at T -> rd_addr 0..5 during T+1..T+6, snap_valid at T+8 with those six bytes, bcd_err=0.
REQ-036 snap_ready held low 20 cycles, start pulsed twice meanwhile -> outputs stable, no rd_en; ready=1 -> IDLE next cycle, no extra sequence.
REQ-037 rst=1 at T+4 -> next cycle rd_en=0, busy=0, snap_valid=0, fields 0x00.
REQ-038 With the macro: seconds=0x60 -> bcd_err=1; months=0x00 -> bcd_err=1; hour=0x1A -> bcd_err=1. Without the macro, the same cases -> bcd_err=0.
REQ-039 Memory contents changed mid-sequence -> fields at T+8 equal the bytes read in their slots; fields before T+8 show the prior snapshot.
REQ-040 Back-to-back: handshake at cycle H, start at H+1 -> second sequence rd_en at H+2; start at H is ignored.
